// File: rtl/thmn_bank_wave.sv
// Bank of CH weighted NCL threshold gates with hysteresis (THmnWw), plus
// bank-wide completion detection and a DATA->NULL wave counter.
module thmn_bank_wave #(
  parameter int              CH      = 4,
  parameter int              N       = 3,
  parameter int              M       = 3,
  parameter logic [4*N-1:0]  W       = {N{4'd1}},
  parameter logic [CH-1:0]   RST_VAL = {CH{1'b0}},
  parameter int              CW      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [CH*N-1:0] a,
  output logic [CH-1:0]   y,
  output logic            all_data,
  output logic            all_null,
  output logic [CW-1:0]   wave_cnt,
  output logic            wave_done
);

  // Wide enough for 8 inputs of weight 15.
  localparam int SW = 7;

  function automatic int weight_total();
    int t;
    t = 0;
    for (int i = 0; i < N; i++) begin
      t = t + int'(W[4*i +: 4]);
    end
    return t;
  endfunction

  localparam int              WSUM = weight_total();
  localparam logic [SW-1:0]   M_V  = M[SW-1:0];

  if (CH < 1) begin : g_bad_ch
    $error("thmn_bank_wave: CH must be >= 1");
  end
  if ((N < 1) || (N > 8)) begin : g_bad_n
    $error("thmn_bank_wave: N must be in 1..8");
  end
  if ((M < 1) || (M > WSUM)) begin : g_bad_m
    $error("thmn_bank_wave: M must be in 1..sum of weights");
  end
  if (CW < 1) begin : g_bad_cw
    $error("thmn_bank_wave: CW must be >= 1");
  end

  typedef enum logic {
    WAIT_DATA = 1'b0,
    WAIT_NULL = 1'b1
  } state_t;

  // A bank that resets to all-DATA must first see a NULL before counting.
  localparam state_t RST_STATE = (&RST_VAL) ? WAIT_NULL : WAIT_DATA;

  logic [CH-1:0]  y_r;
  logic [CH-1:0]  y_nxt_s;
  logic [SW-1:0]  sum_s [CH];
  state_t         state_r;
  state_t         state_nxt_s;
  logic [CW-1:0]  cnt_r;
  logic [CW-1:0]  cnt_nxt_s;
  logic           done_r;
  logic           done_nxt_s;
  logic           all_data_s;
  logic           all_null_s;

  // Weighted input sum per channel.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      sum_s[c] = {SW{1'b0}};
      for (int i = 0; i < N; i++) begin
        if (a[c*N + i]) begin
          sum_s[c] = sum_s[c] + {3'b000, W[4*i +: 4]};
        end else begin
          sum_s[c] = sum_s[c];
        end
      end
    end
  end

  // Hysteresis: set at threshold, clear only when every weighted input is low.
  always_comb begin
    y_nxt_s = y_r;
    for (int c = 0; c < CH; c++) begin
      if (sum_s[c] >= M_V) begin
        y_nxt_s[c] = 1'b1;
      end else if (sum_s[c] == {SW{1'b0}}) begin
        y_nxt_s[c] = 1'b0;
      end else begin
        y_nxt_s[c] = y_r[c];
      end
    end
  end

  // Gate output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_r <= RST_VAL;
    end else if (en) begin
      y_r <= y_nxt_s;
    end else begin
      y_r <= y_r;
    end
  end

  assign all_data_s = &y_r;
  assign all_null_s = ~|y_r;

  // Wave tracker next-state: a wave completes on the NULL following a full DATA.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    done_nxt_s  = 1'b0;
    if (en) begin
      case (state_r)
        WAIT_DATA: begin
          if (all_data_s) begin
            state_nxt_s = WAIT_NULL;
          end else begin
            state_nxt_s = WAIT_DATA;
          end
        end
        WAIT_NULL: begin
          if (all_null_s) begin
            state_nxt_s = WAIT_DATA;
            cnt_nxt_s   = cnt_r + CW'(1'b1);
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = WAIT_NULL;
          end
        end
        default: begin
          state_nxt_s = RST_STATE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Wave tracker state, counter and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RST_STATE;
      cnt_r   <= {CW{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign y         = y_r;
  assign all_data  = all_data_s;
  assign all_null  = all_null_s;
  assign wave_cnt  = cnt_r;
  assign wave_done = done_r;

endmodule

// File: tb/tb_thmn_bank_wave.sv
// Directed-vector bench for thmn_bank_wave across four parameterisations.
module tb_thmn_bank_wave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_f, en_f;
  logic en_on;
  assign en_on = 1'b1;

  logic [11:0] a_d, a_f, a_c;
  logic [3:0]  a_o;
  logic [3:0]  y_d, y_f, y_c;
  logic [0:0]  y_o;
  logic        ad_d, an_d, done_d, ad_o, an_o, done_o;
  logic        ad_f, an_f, done_f, ad_c, an_c, done_c;
  logic [7:0]  cnt_d, cnt_o, cnt_f;
  logic [1:0]  cnt_c;

  int n_vec = 0;
  int n_err = 0;
  int cw_pulses = 0;
  logic [1:0] exp_cw [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  thmn_bank_wave u_def (
    .clk(clk), .rst(rst), .en(en_on), .a(a_d), .y(y_d),
    .all_data(ad_d), .all_null(an_d), .wave_cnt(cnt_d), .wave_done(done_d)
  );

  thmn_bank_wave #(.CH(1), .N(4), .M(3), .W(16'h2111), .RST_VAL(1'b0)) u_one (
    .clk(clk), .rst(rst), .en(en_on), .a(a_o), .y(y_o),
    .all_data(ad_o), .all_null(an_o), .wave_cnt(cnt_o), .wave_done(done_o)
  );

  thmn_bank_wave #(.RST_VAL(4'hF)) u_rf (
    .clk(clk), .rst(rst_f), .en(en_f), .a(a_f), .y(y_f),
    .all_data(ad_f), .all_null(an_f), .wave_cnt(cnt_f), .wave_done(done_f)
  );

  thmn_bank_wave #(.CW(2)) u_cw (
    .clk(clk), .rst(rst), .en(en_on), .a(a_c), .y(y_c),
    .all_data(ad_c), .all_null(an_c), .wave_cnt(cnt_c), .wave_done(done_c)
  );

  always @(negedge clk) begin
    if (done_c) cw_pulses = cw_pulses + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst_f = 1'b1; en_f = 1'b1;
    a_d = 12'h000; a_o = 4'h0; a_f = 12'hFFF; a_c = 12'h000;
    #1;
    check_val("rst y", 32'(y_d), 32'h0);
    check_val("rst cnt", 32'(cnt_d), 32'h0);
    check_val("rst done", 32'(done_d), 32'h0);
    check_val("rst all_null", 32'(an_d), 32'h1);
    check_val("rst y rstval F", 32'(y_f), 32'hF);
    tick(); tick();
    rst = 1'b0; rst_f = 1'b0;

    // TH33 channel 0 hysteresis
    a_d = 12'h003; tick();
    check_val("th33 011", 32'(y_d[0]), 32'h0);
    a_d = 12'h007; #1;
    check_val("th33 latency", 32'(y_d[0]), 32'h0);
    tick();
    check_val("th33 111", 32'(y_d[0]), 32'h1);
    a_d = 12'h001; tick();
    check_val("th33 001 hold", 32'(y_d[0]), 32'h1);
    a_d = 12'h000; tick();
    check_val("th33 000", 32'(y_d[0]), 32'h0);
    check_val("th33 no wave", 32'(cnt_d), 32'h0);

    // One full wave on the default bank
    a_d = 12'hFFF; tick();
    check_val("wave y F", 32'(y_d), 32'hF);
    check_val("wave all_data", 32'(ad_d), 32'h1);
    a_d = 12'hFF8; tick();
    check_val("wave partial y", 32'(y_d), 32'hE);
    check_val("wave partial all_null", 32'(an_d), 32'h0);
    check_val("wave partial done", 32'(done_d), 32'h0);
    a_d = 12'h000; tick();
    check_val("wave null y", 32'(y_d), 32'h0);
    check_val("wave null done early", 32'(done_d), 32'h0);
    check_val("wave null cnt early", 32'(cnt_d), 32'h0);
    tick();
    check_val("wave done pulse", 32'(done_d), 32'h1);
    check_val("wave cnt 1", 32'(cnt_d), 32'h1);
    tick();
    check_val("wave done drop", 32'(done_d), 32'h0);
    check_val("wave cnt hold", 32'(cnt_d), 32'h1);

    // CH=1, N=4, weights 2,1,1,1
    a_o = 4'b1000; tick();
    check_val("w2111 s2", 32'(y_o), 32'h0);
    a_o = 4'b1001; tick();
    check_val("w2111 s3", 32'(y_o), 32'h1);
    a_o = 4'b1000; tick();
    check_val("w2111 hold", 32'(y_o), 32'h1);
    a_o = 4'b0000; tick();
    check_val("w2111 s0", 32'(y_o), 32'h0);
    tick();
    check_val("w2111 done", 32'(done_o), 32'h1);
    check_val("w2111 cnt", 32'(cnt_o), 32'h1);

    // RST_VAL=F: build up three waves, then reset asynchronously mid-wave
    for (int k = 0; k < 3; k++) begin
      a_f = 12'h000; tick(); tick();
      a_f = 12'hFFF; tick(); tick();
    end
    check_val("rf cnt 3", 32'(cnt_f), 32'h3);
    a_f = 12'h1C7; tick();
    check_val("rf y 5", 32'(y_f), 32'h5);
    #2;
    rst_f = 1'b1;
    #1;
    check_val("rf async y", 32'(y_f), 32'hF);
    check_val("rf async cnt", 32'(cnt_f), 32'h0);
    check_val("rf async done", 32'(done_f), 32'h0);
    a_f = 12'h000;
    tick(); tick();
    rst_f = 1'b0;
    tick();
    check_val("rf null y", 32'(y_f), 32'h0);
    check_val("rf null done early", 32'(done_f), 32'h0);
    tick();
    check_val("rf done", 32'(done_f), 32'h1);
    check_val("rf cnt 1", 32'(cnt_f), 32'h1);
    tick();
    check_val("rf done drop", 32'(done_f), 32'h0);

    // en=0 freezes everything
    en_f = 1'b0; a_f = 12'hFFF;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val("en0 y", 32'(y_f), 32'h0);
      check_val("en0 cnt", 32'(cnt_f), 32'h1);
      check_val("en0 done", 32'(done_f), 32'h0);
    end
    en_f = 1'b1; tick();
    check_val("en1 y", 32'(y_f), 32'hF);

    // CW=2 wrap over five waves
    for (int k = 0; k < 5; k++) begin
      a_c = 12'hFFF; tick();
      check_val("cw2 quiet", 32'(done_c), 32'h0);
      tick();
      a_c = 12'h000; tick(); tick();
      check_val("cw2 done", 32'(done_c), 32'h1);
      check_val("cw2 cnt", 32'(cnt_c), 32'(exp_cw[k]));
    end
    tick();
    check_val("cw2 done drop", 32'(done_c), 32'h0);
    check_val("cw2 pulses", 32'(cw_pulses), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
